// File: rtl/sha3_pkg.sv
// Types and constants shared by the OCM burst reader and its beat buffer.
package sha3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef logic [127:0] beat_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;

  // Byte offset of the burst holding a beat index; aligning the index down to
  // a burst boundary keeps every burst inside one 4 KB page.
  function automatic logic [31:0] burst_offset(input logic [31:0] idx,
                                               input logic [31:0] blen);
    return (idx & ~(blen - 32'd1)) << 4;
  endfunction

endpackage

// File: rtl/beat_fifo.sv
// First-word-fall-through beat buffer between the AXI read channel and the dfsm.
module beat_fifo
  import sha3_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  push,
  input  beat_t push_data,
  input  logic  pop,
  output beat_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  beat_t           mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            push_ok;
  logic            pop_ok;

  // A pop frees the slot in the same cycle, so a full buffer can still take a push.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
        2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

endmodule

// File: rtl/ocm_burst_reader.sv
// Fetches one aligned AXI4 INCR burst of 128-bit OCM beats per request and
// hands the beats to the dfsm through a small FWFT buffer.
//
// state | meaning
// IDLE  | waiting for a rising edge on init_master_txn
// ADDR  | read address presented, waiting for arready
// DATA  | accepting beats into the buffer
// DRAIN | burst over, waiting for the dfsm to empty the buffer
// DONE  | one-cycle read_done pulse
module ocm_burst_reader
  import sha3_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          BURST_LEN  = 4,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init_master_txn,
  input  logic [31:0]  read_addr_index,
  output logic [127:0] ocm_data_out,
  output logic         bus_data_valid,
  input  logic         dfsm_read_ready,
  output logic         read_active,
  output logic         read_done,
  output logic         read_error,
  output logic [31:0]  m_axi_araddr,
  output logic [7:0]   m_axi_arlen,
  output logic [2:0]   m_axi_arsize,
  output logic [1:0]   m_axi_arburst,
  output logic         m_axi_arvalid,
  input  logic         m_axi_arready,
  input  logic [127:0] m_axi_rdata,
  input  logic [1:0]   m_axi_rresp,
  input  logic         m_axi_rlast,
  input  logic         m_axi_rvalid,
  output logic         m_axi_rready
);

  localparam logic [4:0] LEN_C = 5'(BURST_LEN);

  state_t      state;
  state_t      state_nxt;
  logic        init_q;
  logic        req_edge;
  logic [31:0] idx_q;
  logic [4:0]  beat_cnt;
  logic [4:0]  cnt_nxt;
  logic        at_len;
  logic        beat_acc;
  logic        err_q;
  logic        fifo_full;
  logic        fifo_empty;
  beat_t       fifo_head;

  assign req_edge = init_master_txn & ~init_q;
  assign beat_acc = m_axi_rvalid & m_axi_rready;
  assign cnt_nxt  = beat_cnt + 5'd1;
  assign at_len   = (cnt_nxt == LEN_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_edge) state_nxt = ST_ADDR;
      ST_ADDR:  if (m_axi_arvalid && m_axi_arready) state_nxt = ST_DATA;
      ST_DATA:  if (beat_acc && (m_axi_rlast || at_len)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    read_active   = 1'b0;
    read_done     = 1'b0;
    case (state)
      ST_ADDR:  begin m_axi_arvalid = 1'b1; read_active = 1'b1; end
      ST_DATA:  begin m_axi_rready = ~fifo_full; read_active = 1'b1; end
      ST_DRAIN: read_active = 1'b1;
      ST_DONE:  read_done = 1'b1;
      default:  ;
    endcase
  end

  // init_q resets high so a request level held through reset does not fire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_q   <= 1'b1;
      idx_q    <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      init_q <= init_master_txn;
      if (state == ST_IDLE && req_edge) begin
        idx_q    <= read_addr_index;
        beat_cnt <= '0;
      end
      if (beat_acc) begin
        beat_cnt <= cnt_nxt;
        // rlast must coincide exactly with the last expected beat.
        if (m_axi_rresp != AXI_RESP_OKAY || (m_axi_rlast != at_len)) err_q <= 1'b1;
      end
    end
  end

  assign m_axi_araddr  = BASE_ADDR + burst_offset(idx_q, 32'(BURST_LEN));
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = AXI_SIZE_16B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign read_error    = err_q;

  beat_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_beat_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (beat_acc),
    .push_data (m_axi_rdata),
    .pop       (bus_data_valid & dfsm_read_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus_data_valid = ~fifo_empty;
  assign ocm_data_out   = bus_data_valid ? fifo_head : '0;

endmodule

// File: tb/tb_ocm_burst_reader.sv
// Scoreboard bench: an OCM/AXI slave model feeds two reader instances and a
// monitor compares every delivered beat with the expected queue.
module tb_ocm_burst_reader;

  localparam logic [31:0] BASE_A = 32'h0000_1000;
  localparam int          BL_A   = 4;
  localparam int          FD_A   = 2;
  localparam logic [31:0] BASE_B = 32'h0002_0000;
  localparam int          BL_B   = 1;
  localparam int          FD_B   = 4;

  logic         clk, reset_n;
  logic         init_a, init_b, dfsm_ready;
  logic [31:0]  idx_a, idx_b;
  logic         arready, rvalid, rlast;
  logic [127:0] rdata;
  logic [1:0]   rresp;

  logic [127:0] a_data, b_data;
  logic         a_valid, a_active, a_done, a_err, a_arvalid, a_rready;
  logic         b_valid, b_active, b_done, b_err, b_arvalid, b_rready;
  logic [31:0]  a_araddr, b_araddr;
  logic [7:0]   a_arlen, b_arlen;
  logic [2:0]   a_arsize, b_arsize;
  logic [1:0]   a_arburst, b_arburst;

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q[$];
  logic [31:0]  exp_addr_q[$];
  logic [127:0] ocm [logic [31:0]];
  logic [31:0]  salt;
  bit  sel = 0, no_stall = 0, no_last = 0, force_low = 0, rand_ready = 0, slave_kill = 0;
  int  err_beat = -1, early_last = 0;
  int  done_a = 0, done_b = 0, ar_cnt = 0, beats_acc = 0;

  ocm_burst_reader #(.BASE_ADDR(BASE_A), .BURST_LEN(BL_A), .FIFO_DEPTH(FD_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .init_master_txn(init_a), .read_addr_index(idx_a),
    .ocm_data_out(a_data), .bus_data_valid(a_valid), .dfsm_read_ready(dfsm_ready),
    .read_active(a_active), .read_done(a_done), .read_error(a_err),
    .m_axi_araddr(a_araddr), .m_axi_arlen(a_arlen), .m_axi_arsize(a_arsize),
    .m_axi_arburst(a_arburst), .m_axi_arvalid(a_arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(a_rready));

  ocm_burst_reader #(.BASE_ADDR(BASE_B), .BURST_LEN(BL_B), .FIFO_DEPTH(FD_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .init_master_txn(init_b), .read_addr_index(idx_b),
    .ocm_data_out(b_data), .bus_data_valid(b_valid), .dfsm_read_ready(dfsm_ready),
    .read_active(b_active), .read_done(b_done), .read_error(b_err),
    .m_axi_araddr(b_araddr), .m_axi_arlen(b_arlen), .m_axi_arsize(b_arsize),
    .m_axi_arburst(b_arburst), .m_axi_arvalid(b_arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(b_rready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ocm_rd(input logic [31:0] a);
    if (ocm.exists(a)) return ocm[a];
    return {a ^ salt, ~a, a * 32'd2654435761, salt ^ 32'h5a5a_0f0f};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: the burst covering idx starts at the index rounded down to a
  // multiple of the burst length; beats come from consecutive 16-byte words.
  task automatic push_exp(input bit s, input logic [31:0] idx, input int nbeats);
    logic [31:0] bl, a;
    bl = s ? 32'(BL_B) : 32'(BL_A);
    a  = (s ? BASE_B : BASE_A) + (idx / bl) * bl * 32'd16;
    exp_addr_q.push_back(a);
    for (int k = 0; k < nbeats; k++) exp_q.push_back(ocm_rd(a + 32'(k) * 32'd16));
  endtask

  task automatic wait_done(input bit s, input int d0);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((s ? done_b : done_a) != d0) break;
    end
    if (i == 400) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_read_done required=read_done");
    end
  endtask

  task automatic run_burst(input bit s, input logic [31:0] idx);
    int d0;
    d0 = s ? done_b : done_a;
    @(negedge clk);
    if (s) begin idx_b = idx; init_b = 1'b1; end
    else   begin idx_a = idx; init_a = 1'b1; end
    @(negedge clk);
    chk("active_after_edge", s ? b_active : a_active, 1'b1);
    init_a = 1'b0; init_b = 1'b0;
    wait_done(s, d0);
    chk("active_after_done", s ? b_active : a_active, 1'b0);
    cyc(2);
    chk("done_once", (s ? done_b : done_a) - d0, 1);
    chk("all_beats_out", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    slave_kill = 1'b1;
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
  endtask

  // AXI slave backed by the OCM image; handshakes are decided at the negedge
  // from values that stay stable until the next posedge.
  initial begin
    bit busy, ar_p, r_p;
    logic [31:0] base, bl;
    int n, i;
    busy = 0; ar_p = 0; r_p = 0; n = 0; i = 0; base = '0; bl = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0;
    forever begin
      @(negedge clk);
      if (slave_kill) begin
        busy = 0; ar_p = 0; r_p = 0; slave_kill = 0;
      end else begin
        if (ar_p) begin busy = 1; i = 0; end
        if (r_p) begin i++; if (i == n) busy = 0; end
      end
      arready = !busy && (no_stall || $urandom_range(0, 1) == 1);
      if (busy) begin
        rvalid = no_stall || ($urandom_range(0, 2) != 0);
        rdata  = ocm_rd(base + 32'(i) * 32'd16);
        rresp  = (i == err_beat) ? 2'b10 : 2'b00;
        rlast  = (i == n - 1) && !no_last;
      end else begin
        rvalid = 0; rlast = 0; rresp = 2'b00;
      end
      ar_p = (sel ? b_arvalid : a_arvalid) && arready;
      if (ar_p) begin
        base = sel ? b_araddr : a_araddr;
        bl   = sel ? 32'(BL_B) : 32'(BL_A);
        n    = (early_last > 0) ? early_last : int'(bl);
        ar_cnt++;
        if (exp_addr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ar actual=%h required=no_request", base);
        end else begin
          chk("araddr", base, exp_addr_q.pop_front());
        end
        chk("ar_ctrl", sel ? {b_arlen, b_arsize, b_arburst} : {a_arlen, a_arsize, a_arburst},
            {8'(bl - 32'd1), 3'b100, 2'b01});
      end
      r_p = rvalid && (sel ? b_rready : a_rready);
      if (r_p) beats_acc++;
    end
  end

  // Monitor: drives the dfsm ready, pops and compares delivered beats.
  initial begin
    logic [127:0] prev_d, e;
    bit prev_hold;
    prev_hold = 0; prev_d = '0;
    dfsm_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (a_done) done_a++;
      if (b_done) done_b++;
      dfsm_ready = force_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (prev_hold && a_valid) chk("hold_stable", a_data, prev_d);
      prev_hold = a_valid && !dfsm_ready;
      prev_d = a_data;
      for (int s = 0; s < 2; s++) begin
        if ((s == 0 ? a_valid : b_valid) && dfsm_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_beat actual=%h required=none", s == 0 ? a_data : b_data);
          end else begin
            e = exp_q.pop_front();
            chk(s == 0 ? "beat_a" : "beat_b", s == 0 ? a_data : b_data, e);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0, d0, a0;
    logic [7:0] msg [144];
    logic [127:0] beat;
    reset_n = 1'b0; init_a = 0; init_b = 0; idx_a = '0; idx_b = '0;
    salt = $urandom;
    cyc(3);
    chk("reset_a", {a_arvalid, a_rready, a_valid, a_active, a_done, a_err, a_data}, '0);
    chk("reset_b", {b_arvalid, b_rready, b_valid, b_active, b_done, b_err, b_data}, '0);
    reset_n = 1'b1;
    cyc(2);

    // Basic burst: index 5 lands in the burst at 0x1040, beats A..D.
    for (int k = 0; k < 4; k++) ocm[32'h1040 + 32'(k) * 16] = {4{32'hA0A0_0000 + 32'(k)}};
    no_stall = 1; rand_ready = 0;
    push_exp(0, 32'd5, 4);
    run_burst(0, 32'd5);
    chk("basic_err", a_err, 1'b0);

    // Random indices with random slave and dfsm stalls, including address wrap.
    no_stall = 0; rand_ready = 1;
    for (int t = 0; t < 6; t++) begin
      logic [31:0] idx;
      idx = (t == 5) ? 32'hFFFF_FFFF : $urandom;
      push_exp(0, idx, 4);
      run_burst(0, idx);
    end
    chk("random_err", a_err, 1'b0);

    // Backpressure: only FIFO_DEPTH beats may be taken while the dfsm stalls.
    no_stall = 1; force_low = 1;
    b0 = beats_acc;
    push_exp(0, 32'd40, 4);
    @(negedge clk); idx_a = 32'd40; init_a = 1;
    @(negedge clk); init_a = 0;
    cyc(10);
    chk("bp_beats", beats_acc - b0, FD_A);
    chk("bp_rready", a_rready, 1'b0);
    chk("bp_valid", a_valid, 1'b1);
    force_low = 0;
    d0 = done_a;
    wait_done(0, d0);
    cyc(2);
    chk("bp_all_out", exp_q.size(), 0);

    // Held request plus an extra edge while busy: one burst only.
    rand_ready = 1; no_stall = 0;
    a0 = ar_cnt; d0 = done_a;
    push_exp(0, 32'd77, 4);
    force_low = 1;
    @(negedge clk); idx_a = 32'd77; init_a = 1;
    cyc(4); init_a = 0;
    cyc(1); init_a = 1;
    cyc(3); force_low = 0;
    cyc(60);
    chk("held_ar_count", ar_cnt - a0, 1);
    chk("held_done_count", done_a - d0, 1);
    init_a = 0;
    cyc(2);

    // Error response on beat 2 still delivers every beat.
    err_beat = 1;
    push_exp(0, 32'd123, 4);
    run_burst(0, 32'd123);
    chk("rresp_err", a_err, 1'b1);
    err_beat = -1;

    // Reset with two beats buffered.
    no_stall = 1; force_low = 1;
    b0 = beats_acc;
    push_exp(0, 32'd8, 4);
    @(negedge clk); idx_a = 32'd8; init_a = 1;
    @(negedge clk); init_a = 0;
    cyc(8);
    chk("rst_buffered", beats_acc - b0, 2);
    @(negedge clk);
    #2 reset_n = 1'b0; slave_kill = 1;
    #1 chk("rst_mid_outputs", {a_arvalid, a_rready, a_valid, a_active, a_done, a_err, a_data}, '0);
    exp_q.delete(); exp_addr_q.delete();
    force_low = 0;
    d0 = done_a;
    cyc(3);
    reset_n = 1'b1;
    cyc(5);
    chk("rst_no_done", done_a - d0, 0);
    chk("rst_idle", {a_active, a_valid}, 2'b00);
    no_stall = 0;
    push_exp(0, 32'd200, 4);
    run_burst(0, 32'd200);
    chk("err_cleared", a_err, 1'b0);

    // rlast early on beat 3.
    early_last = 3;
    push_exp(0, 32'd300, 3);
    run_burst(0, 32'd300);
    chk("early_last_err", a_err, 1'b1);
    early_last = 0;

    // Burst length reached without rlast.
    do_reset();
    chk("reset_clears_err", a_err, 1'b0);
    no_last = 1;
    push_exp(0, 32'd64, 4);
    run_burst(0, 32'd64);
    chk("missing_last_err", a_err, 1'b1);
    no_last = 0;

    // 139-byte message over nine single-beat bursts, byte lane k = byte 16j+k.
    sel = 1; rand_ready = 1;
    for (int i = 0; i < 144; i++) msg[i] = (i < 139) ? 8'($urandom) : 8'h00;
    for (int j = 0; j < 9; j++) begin
      for (int k = 0; k < 16; k++) beat[8*k +: 8] = msg[16*j + k];
      ocm[BASE_B + 32'(j) * 16] = beat;
    end
    for (int j = 0; j < 9; j++) begin
      for (int k = 0; k < 16; k++) beat[8*k +: 8] = msg[16*j + k];
      exp_addr_q.push_back(BASE_B + 32'(j) * 16);
      exp_q.push_back(beat);
      run_burst(1, 32'(j));
    end
    chk("msg_err", b_err, 1'b0);
    chk("msg_addr_all_used", exp_addr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ocm_burst_reader.md
OCM_BURST_READER -- requirements
Module: ocm_burst_reader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte base of the OCM message buffer.
REQ-002 SHALL have parameter BURST_LEN, default 4: beats per burst; legal values are 1, 2, 4, 8 or 16.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: depth of the beat buffer; power of two, at least 2.
REQ-004 SHALL have ports: clk, input, 1 bit, single clock; reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have ports: init_master_txn, input, 1 bit, request one burst (rising edge); read_addr_index, input, 32 bits, 128-bit beat index.
REQ-006 SHALL have ports: ocm_data_out, output, 128 bits, beat to dfsm; bus_data_valid, output, 1 bit; dfsm_read_ready, input, 1 bit, beat accepted.
REQ-007 SHALL have ports: read_active, output, 1 bit, burst in progress; read_done, output, 1 bit, one-cycle burst-complete pulse; read_error, output, 1 bit, sticky.
REQ-008 SHALL have AXI4 read-master ports m_axi_araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arvalid, arready, rdata[127:0], rresp[1:0], rlast, rvalid and rready, all prefixed m_axi_.

Function
REQ-009 SHALL detect the request on a registered rising edge of init_master_txn; a level held high SHALL start only one burst.
REQ-010 SHALL run an FSM with states IDLE, ADDR, DATA, DRAIN and DONE.
- IDLE to ADDR on a request edge.
- ADDR to DATA on arvalid and arready.
- DATA to DRAIN on an accepted beat with rlast set.
- DRAIN to DONE when the FIFO is empty.
- DONE to IDLE unconditionally, after one cycle.
REQ-011 SHALL ignore a request edge in any state other than IDLE; the edge is neither queued nor counted.
REQ-012 SHALL drive araddr = BASE_ADDR + ({read_addr_index[31:log2 BURST_LEN], log2 BURST_LEN zero bits} << 4). Alignment guarantees a burst never crosses 4 KB. Address arithmetic is 32-bit wrapping.
REQ-013 SHALL drive arlen = BURST_LEN-1, arsize = 3'b100 and arburst = INCR. arvalid SHALL be high only in ADDR and SHALL hold until arready.
REQ-014 SHALL capture read_addr_index on the request edge and hold it constant until the burst leaves ADDR.
REQ-015 SHALL drive rready = DATA and FIFO not full; a beat is accepted when rvalid and rready are both high.
REQ-016 SHALL push rdata into the FIFO on each accepted beat. ocm_data_out SHALL be the FIFO head and bus_data_valid SHALL be FIFO not empty. A pop occurs on bus_data_valid and dfsm_read_ready.
REQ-017 SHALL allow a push and a pop in the same cycle when the FIFO is full: the occupancy stays unchanged and no beat is lost.
REQ-018 SHALL keep ocm_data_out stable while bus_data_valid is high and dfsm_read_ready is low.
REQ-019 SHALL assert read_active from the cycle after the request edge until DONE.
REQ-020 SHALL pulse read_done for exactly one cycle, in DONE.
REQ-021 SHALL set read_error on any accepted beat with rresp != 2'b00. The beat SHALL still be delivered, and read_error SHALL clear only on reset.
REQ-022 SHALL count accepted beats. If rlast arrives before BURST_LEN beats, or the count reaches BURST_LEN without rlast, it SHALL set read_error and move to DRAIN.

Reset
REQ-023 SHALL, while reset_n is low, drive arvalid, rready, bus_data_valid, read_active, read_done and read_error to 0, ocm_data_out to 0, empty the FIFO and enter IDLE.
REQ-024 SHALL, on reset mid-burst, discard buffered beats and take no action on reset release until a new request edge.

Structure
REQ-025 SHALL place the FSM state encoding, the AXI burst/resp constants and a 128-bit beat type in the shared package sha3_pkg.
REQ-026 SHALL implement the beat buffer as one sub-module, beat_fifo: synchronous, first-word-fall-through, with full/empty flags and asynchronous active-low reset.

Verification
REQ-027 SHALL cover basic burst:
- Stimulus: BASE_ADDR=0x1000, index=5, BURST_LEN=4, slave returns beats A..D with no stalls.
- Response: araddr=0x1040 and arlen=3; beats A..D delivered in order; one read_done pulse; read_error=0.
REQ-028 SHALL cover backpressure:
- Stimulus: dfsm_read_ready low for 10 cycles during a burst.
- Response: rready drops after FIFO_DEPTH beats; no beat is lost or duplicated; ocm_data_out stays stable.
REQ-029 SHALL cover a held request:
- Stimulus: init_master_txn held high for 3 bursts' time, plus an edge while busy.
- Response: exactly one burst is issued.
REQ-030 SHALL cover error responses:
- Stimulus: rresp=2'b10 on beat 2, or rlast early on beat 3.
- Response: read_error=1; all received beats delivered; read_done still pulses.
REQ-031 SHALL cover reset mid-burst:
- Stimulus: reset_n low during DATA with 2 beats buffered.
- Response: all outputs 0 and FIFO empty; no read_done pulse; the next request works normally.
REQ-032 SHALL cover the full dfsm hand-off:
- Stimulus: 139-byte message, 9 sequential indices, BURST_LEN=1.
- Response: 9 beats delivered with byte-exact data matching OCM contents.
